// File: rtl/sw_timer.sv
// rtl/sw_timer.sv - software-programmable one-shot/periodic down-counter timer
// Counts selected us/ms/sec ticks from a shadowed load value and raises a sticky irq on expiry.
module sw_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk_200,
  input  logic             resetb,
  input  logic             us_tick,
  input  logic             ms_tick,
  input  logic             sec_tick,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       tb_sel,
  input  logic             mode,
  input  logic [CNT_W-1:0] load_val,
  input  logic             irq_clr,
  output logic [CNT_W-1:0] cur_cnt,
  output logic             busy,
  output logic             expire_pulse,
  output logic             irq_sts
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] sh_load, sh_load_nxt;
  logic [1:0]       sh_tb_sel, sh_tb_sel_nxt;
  logic             sh_mode, sh_mode_nxt;
  logic             sel_tick;
  logic             start_ok;
  logic             expire;
  logic             irq_nxt;

  always_comb begin
    sel_tick = 1'b0;
    case (sh_tb_sel)
      2'b00:   sel_tick = us_tick;
      2'b01:   sel_tick = ms_tick;
      2'b10:   sel_tick = sec_tick;
      default: sel_tick = 1'b0;
    endcase
  end

  // Priority is stop > start > expiring tick.
  assign start_ok = start && (load_val != '0) && !stop;
  assign expire   = (state == RUN) && sel_tick && (cnt == CNT_W'(1)) && !stop && !start_ok;
  assign irq_nxt  = expire | (irq_sts & ~irq_clr);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    sh_load_nxt   = sh_load;
    sh_tb_sel_nxt = sh_tb_sel;
    sh_mode_nxt   = sh_mode;
    if (stop) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (start_ok) begin
      state_nxt     = RUN;
      cnt_nxt       = load_val;
      sh_load_nxt   = load_val;
      sh_tb_sel_nxt = tb_sel;
      sh_mode_nxt   = mode;
    end else if ((state == RUN) && sel_tick) begin
      if (cnt > CNT_W'(1)) begin
        cnt_nxt = cnt - CNT_W'(1);
      end else if (expire) begin
        if (sh_mode) begin
          cnt_nxt = sh_load;
        end else begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end
      end
    end
  end

  always_ff @(posedge clk_200 or negedge resetb) begin
    if (!resetb) begin
      state        <= IDLE;
      cnt          <= '0;
      sh_load      <= '0;
      sh_tb_sel    <= 2'b00;
      sh_mode      <= 1'b0;
      busy         <= 1'b0;
      expire_pulse <= 1'b0;
      irq_sts      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      sh_load      <= sh_load_nxt;
      sh_tb_sel    <= sh_tb_sel_nxt;
      sh_mode      <= sh_mode_nxt;
      busy         <= (state_nxt == RUN);
      expire_pulse <= expire;
      irq_sts      <= irq_nxt;
    end
  end

  assign cur_cnt = cnt;

endmodule

// File: tb/tb_sw_timer.sv
// tb/tb_sw_timer.sv - directed self-checking bench for sw_timer
`timescale 1ns/1ps
module tb_sw_timer;

  logic        clk_200 = 1'b0;
  logic        resetb = 1'b0;
  logic        us_tick = 1'b0, ms_tick = 1'b0, sec_tick = 1'b0;
  logic        start = 1'b0, stop = 1'b0, mode = 1'b0, irq_clr = 1'b0;
  logic [1:0]  tb_sel = 2'b00;
  logic [15:0] load_val = 16'd0;
  logic [15:0] cur_cnt;
  logic        busy, expire_pulse, irq_sts;
  int          total = 0;
  int          bad = 0;

  sw_timer #(.CNT_W(16)) dut (
    .clk_200(clk_200), .resetb(resetb), .us_tick(us_tick), .ms_tick(ms_tick),
    .sec_tick(sec_tick), .start(start), .stop(stop), .tb_sel(tb_sel), .mode(mode),
    .load_val(load_val), .irq_clr(irq_clr), .cur_cnt(cur_cnt), .busy(busy),
    .expire_pulse(expire_pulse), .irq_sts(irq_sts)
  );

  always #2.5 clk_200 = ~clk_200;

  task automatic cyc();
    @(posedge clk_200);
    #1;
  endtask

  task automatic do_start(input logic [1:0] sel, input logic m, input logic [15:0] lv);
    tb_sel = sel; mode = m; load_val = lv; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic ms_pulse();
    ms_tick = 1'b1;
    cyc();
    ms_tick = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    cyc(); cyc();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (cur_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cur_cnt); end
    total++; if (expire_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b exp=0", expire_pulse); end
    total++; if (irq_sts !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq_sts); end
    resetb = 1'b1;
    cyc();
  endtask

  task automatic test_one_shot();
    do_start(2'b01, 1'b0, 16'd3);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL os_busy got=%b exp=1", busy); end
    total++; if (cur_cnt !== 16'd3) begin bad++; $display("FAIL os_load got=%0d exp=3", cur_cnt); end
    // inputs changed after start must not affect the running timer
    tb_sel = 2'b00; load_val = 16'd9; mode = 1'b1;
    us_tick = 1'b1; cyc(); us_tick = 1'b0;
    total++; if (cur_cnt !== 16'd3) begin bad++; $display("FAIL os_shadow got=%0d exp=3", cur_cnt); end
    ms_pulse();
    total++; if (cur_cnt !== 16'd2) begin bad++; $display("FAIL os_dec1 got=%0d exp=2", cur_cnt); end
    ms_pulse();
    total++; if (cur_cnt !== 16'd1 || expire_pulse !== 1'b0) begin bad++; $display("FAIL os_dec2 got=%0d/%b exp=1/0", cur_cnt, expire_pulse); end
    ms_pulse();
    total++; if (expire_pulse !== 1'b1) begin bad++; $display("FAIL os_pulse got=%b exp=1", expire_pulse); end
    total++; if (cur_cnt !== 16'd0) begin bad++; $display("FAIL os_cnt0 got=%0d exp=0", cur_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL os_done got=%b exp=0", busy); end
    total++; if (irq_sts !== 1'b1) begin bad++; $display("FAIL os_irq got=%b exp=1", irq_sts); end
    cyc();
    total++; if (expire_pulse !== 1'b0) begin bad++; $display("FAIL os_pulse_width got=%b exp=0", expire_pulse); end
    ms_pulse();
    total++; if (cur_cnt !== 16'd0 || expire_pulse !== 1'b0) begin bad++; $display("FAIL os_done_tick got=%0d/%b exp=0/0", cur_cnt, expire_pulse); end
    irq_clr = 1'b1; cyc(); irq_clr = 1'b0;
    total++; if (irq_sts !== 1'b0) begin bad++; $display("FAIL os_irqclr got=%b exp=0", irq_sts); end
  endtask

  task automatic test_periodic();
    int ecnt = 0;
    int last = -1;
    int n = 0;
    logic       exp_p;
    logic [15:0] exp_c;
    do_start(2'b00, 1'b1, 16'd5);
    for (int k = 1; k <= 20; k++) begin
      for (int i = 0; i < 199; i++) begin
        cyc(); n++;
        total++; if (expire_pulse !== 1'b0) begin bad++; $display("FAIL per_idle tick=%0d got=%b exp=0", k, expire_pulse); end
      end
      us_tick = 1'b1; cyc(); us_tick = 1'b0; n++;
      exp_p = (k % 5 == 0);
      exp_c = (k % 5 == 0) ? 16'd5 : 16'(5 - k % 5);
      total++; if (expire_pulse !== exp_p) begin bad++; $display("FAIL per_pulse tick=%0d got=%b exp=%b", k, expire_pulse, exp_p); end
      total++; if (cur_cnt !== exp_c) begin bad++; $display("FAIL per_cnt tick=%0d got=%0d exp=%0d", k, cur_cnt, exp_c); end
      if (expire_pulse === 1'b1) begin
        ecnt++;
        if (last >= 0) begin
          total++; if (n - last !== 1000) begin bad++; $display("FAIL per_interval got=%0d exp=1000", n - last); end
        end
        last = n;
      end
    end
    total++; if (ecnt !== 4) begin bad++; $display("FAIL per_count got=%0d exp=4", ecnt); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL per_busy got=%b exp=1", busy); end
    do_stop();
    total++; if (busy !== 1'b0 || cur_cnt !== 16'd0) begin bad++; $display("FAIL per_stop got=%b/%0d exp=0/0", busy, cur_cnt); end
    irq_clr = 1'b1; cyc(); irq_clr = 1'b0;
  endtask

  task automatic test_zero_load();
    do_start(2'b01, 1'b0, 16'd0);
    total++; if (busy !== 1'b0 || cur_cnt !== 16'd0) begin bad++; $display("FAIL zero_idle got=%b/%0d exp=0/0", busy, cur_cnt); end
    do_start(2'b01, 1'b0, 16'd4);
    do_start(2'b00, 1'b1, 16'd0);
    total++; if (busy !== 1'b1 || cur_cnt !== 16'd4) begin bad++; $display("FAIL zero_run got=%b/%0d exp=1/4", busy, cur_cnt); end
    // the ignored start must not have switched the time base to us
    us_tick = 1'b1; cyc(); us_tick = 1'b0;
    total++; if (cur_cnt !== 16'd4) begin bad++; $display("FAIL zero_shadow got=%0d exp=4", cur_cnt); end
    do_stop();
  endtask

  task automatic test_stop_expiry();
    do_start(2'b01, 1'b0, 16'd1);
    stop = 1'b1; ms_tick = 1'b1; cyc(); stop = 1'b0; ms_tick = 1'b0;
    total++; if (expire_pulse !== 1'b0 || irq_sts !== 1'b0) begin bad++; $display("FAIL stopexp_pulse got=%b/%b exp=0/0", expire_pulse, irq_sts); end
    total++; if (busy !== 1'b0 || cur_cnt !== 16'd0) begin bad++; $display("FAIL stopexp_state got=%b/%0d exp=0/0", busy, cur_cnt); end
    cyc();
    total++; if (expire_pulse !== 1'b0 || irq_sts !== 1'b0) begin bad++; $display("FAIL stopexp_late got=%b/%b exp=0/0", expire_pulse, irq_sts); end
    stop = 1'b1; load_val = 16'd8; start = 1'b1; cyc(); stop = 1'b0; start = 1'b0;
    total++; if (busy !== 1'b0 || cur_cnt !== 16'd0) begin bad++; $display("FAIL stop_over_start got=%b/%0d exp=0/0", busy, cur_cnt); end
  endtask

  task automatic test_start_over_expiry();
    do_start(2'b01, 1'b0, 16'd2);
    ms_pulse();
    tb_sel = 2'b01; mode = 1'b0; load_val = 16'd6; start = 1'b1; ms_tick = 1'b1;
    cyc(); start = 1'b0; ms_tick = 1'b0;
    total++; if (expire_pulse !== 1'b0 || cur_cnt !== 16'd6 || busy !== 1'b1) begin bad++; $display("FAIL start_over_exp got=%b/%0d/%b exp=0/6/1", expire_pulse, cur_cnt, busy); end
    do_stop();
  endtask

  task automatic test_irq_clr_coincide();
    do_start(2'b01, 1'b0, 16'd1);
    irq_clr = 1'b1; ms_tick = 1'b1; cyc(); irq_clr = 1'b0; ms_tick = 1'b0;
    total++; if (irq_sts !== 1'b1 || expire_pulse !== 1'b1) begin bad++; $display("FAIL irq_set_prio got=%b/%b exp=1/1", irq_sts, expire_pulse); end
    cyc();
    irq_clr = 1'b1; cyc(); irq_clr = 1'b0;
    total++; if (irq_sts !== 1'b0) begin bad++; $display("FAIL irq_clr_alone got=%b exp=0", irq_sts); end
  endtask

  task automatic test_reserved_base();
    do_start(2'b11, 1'b0, 16'd1);
    us_tick = 1'b1; ms_tick = 1'b1; sec_tick = 1'b1;
    cyc(); cyc();
    us_tick = 1'b0; ms_tick = 1'b0; sec_tick = 1'b0;
    total++; if (cur_cnt !== 16'd1 || busy !== 1'b1 || irq_sts !== 1'b0) begin bad++; $display("FAIL reserved got=%0d/%b/%b exp=1/1/0", cur_cnt, busy, irq_sts); end
    do_stop();
  endtask

  task automatic test_reset_midrun();
    do_start(2'b01, 1'b0, 16'd10);
    ms_pulse(); ms_pulse(); ms_pulse();
    total++; if (cur_cnt !== 16'd7) begin bad++; $display("FAIL midrun_cnt got=%0d exp=7", cur_cnt); end
    resetb = 1'b0;
    #0.5;
    total++; if (cur_cnt !== 16'd0 || busy !== 1'b0 || expire_pulse !== 1'b0 || irq_sts !== 1'b0) begin bad++; $display("FAIL midrun_async got=%0d/%b/%b/%b exp=0/0/0/0", cur_cnt, busy, expire_pulse, irq_sts); end
    cyc();
    resetb = 1'b1;
    cyc();
    for (int k = 0; k < 20; k++) begin
      ms_pulse();
      cyc();
      total++; if (expire_pulse !== 1'b0 || busy !== 1'b0 || irq_sts !== 1'b0) begin bad++; $display("FAIL midrun_after tick=%0d got=%b/%b/%b exp=0/0/0", k, expire_pulse, busy, irq_sts); end
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_zero_load();
    test_stop_expiry();
    test_start_over_expiry();
    test_irq_clr_coincide();
    test_reserved_base();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sw_timer.md
SW_TIMER -- requirements
Module: sw_timer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of load value and down-counter.
REQ-002 SHALL have port clk_200  input  1  200 MHz clock; all state on its rising edge.
REQ-003 SHALL have port resetb  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port us_tick  input  1  1-cycle pulse, once per microsecond, from the tick generator.
REQ-005 SHALL have port ms_tick  input  1  1-cycle pulse, once per millisecond.
REQ-006 SHALL have port sec_tick  input  1  1-cycle pulse, once per second.
REQ-007 SHALL have port start  input  1  1-cycle pulse that loads and starts the timer.
REQ-008 SHALL have port stop  input  1  1-cycle pulse that aborts the timer.
REQ-009 SHALL have port tb_sel  input  2  time base: 00 us, 01 ms, 10 sec, 11 reserved (no tick).
REQ-010 SHALL have port mode  input  1  0 one-shot, 1 periodic.
REQ-011 SHALL have port load_val  input  CNT_W  interval in selected ticks.
REQ-012 SHALL have port irq_clr  input  1  1-cycle pulse that clears irq_sts.
REQ-013 SHALL have port cur_cnt  output  CNT_W  current down-counter value.
REQ-014 SHALL have port busy  output  1  high while state is RUN.
REQ-015 SHALL have port expire_pulse  output  1  1-cycle pulse on each expiry.
REQ-016 SHALL have port irq_sts  output  1  sticky expiry flag.

Function
REQ-017 SHALL implement states IDLE, RUN, DONE; busy = (state==RUN).
REQ-018 SHALL latch tb_sel, mode and load_val into shadow registers on an accepted start; inputs changing afterwards SHALL have no effect until the next accepted start.
REQ-019 SHALL accept start in any state when load_val != 0 and stop is low: cnt <= load_val, state <= RUN, next cycle (start while RUN restarts).
REQ-020 SHALL ignore start with load_val == 0: no change to state, cnt or shadow registers.
REQ-021 SHALL define sel_tick = the tick input chosen by the shadow tb_sel; shadow tb_sel 11 SHALL give sel_tick = 0 (timer never expires).
REQ-022 SHALL, in RUN on sel_tick with cnt > 1, decrement cnt by 1; sel_tick in IDLE/DONE SHALL be ignored.
REQ-023 SHALL, in RUN on sel_tick with cnt == 1, expire: one-shot -> cnt <= 0, state <= DONE; periodic -> cnt <= shadow load_val, stay RUN.
REQ-024 SHALL register expire_pulse high exactly one cycle, the cycle after the expiring sel_tick.
REQ-025 SHALL make the interval between consecutive periodic expiries exactly load_val sel_ticks.
REQ-026 SHALL set irq_sts in the same cycle expire_pulse rises; it stays set until irq_clr.
REQ-027 SHALL give set priority when expiry and irq_clr coincide (irq_sts stays 1).
REQ-028 SHALL, on stop, set state <= IDLE, cnt <= 0 next cycle; an expiry in the same cycle SHALL be suppressed (no expire_pulse, no irq_sts set).
REQ-029 SHALL give stop priority over start when both are asserted in one cycle.
REQ-030 SHALL give start priority over a coincident expiring sel_tick (reload, no expiry).
REQ-031 SHALL drive cur_cnt directly from the cnt register; all outputs registered.
REQ-032 SHALL never wrap cnt below 0 or above load_val.

Reset
REQ-033 SHALL, on resetb low, asynchronously force state IDLE, cnt 0, shadow regs 0, busy 0, expire_pulse 0, irq_sts 0.
REQ-034 SHALL discard a run in progress when reset asserts mid-RUN; no expiry after release until a new start.

Verification
REQ-035 SHALL cover one-shot: tb_sel=01, mode=0, load_val=3, start -> expire_pulse one cycle after 3rd ms_tick, state DONE, cur_cnt 0, irq_sts 1.
REQ-036 SHALL cover periodic: tb_sel=00, mode=1, load_val=5 -> expire_pulse every 5 us_ticks (1000 cycles), cur_cnt reloads to 5, 4 expiries observed.
REQ-037 SHALL cover start with load_val=0 in IDLE -> busy stays 0, cur_cnt stays 0.
REQ-038 SHALL cover stop coinciding with expiring tick (load_val=1) -> no expire_pulse, irq_sts 0, IDLE, cur_cnt 0.
REQ-039 SHALL cover irq_clr coinciding with expiry -> irq_sts 1; irq_clr alone later -> irq_sts 0.
REQ-040 SHALL cover resetb low mid-RUN (cur_cnt=7) -> all outputs 0 immediately; no expire_pulse after release across 20 ms_ticks.
